// File: rtl/exe_stage.sv
// Execute stage: ALU with NZCV status register, branch target generation and the
// EX/MEM pipeline register with flush/freeze control.
module exe_stage #(
    parameter int WIDTH  = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [3:0]        exe_cmd,
    input  logic              s_in,
    input  logic              b_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              wb_en_in,
    input  logic [WIDTH-1:0]  val_rn,
    input  logic [WIDTH-1:0]  val2,
    input  logic [WIDTH-1:0]  val_rm,
    input  logic [DEST_W-1:0] dest_in,
    input  logic [WIDTH-1:0]  pc_in,
    input  logic [23:0]       imm24,
    output logic [WIDTH-1:0]  alu_res,
    output logic [WIDTH-1:0]  st_val,
    output logic [DEST_W-1:0] dest,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              valid,
    output logic [3:0]        status,
    output logic              branch_taken,
    output logic [WIDTH-1:0]  branch_addr
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    logic [WIDTH-1:0]  r_alu_res;
    logic [WIDTH-1:0]  r_st_val;
    logic [DEST_W-1:0] r_dest;
    logic              r_wb_en;
    logic              r_mem_r_en;
    logic              r_mem_w_en;
    logic              r_valid;
    logic [3:0]        r_status;

    logic [WIDTH:0]    w_ext;
    logic [WIDTH-1:0]  w_res;
    logic              w_c;
    logic              w_v;
    logic              w_defined;
    logic              w_c_in;
    logic [3:0]        w_flags;
    logic              w_status_we;
    logic [WIDTH-1:0]  w_imm_sext;

    assign w_c_in = r_status[1];

    // Arithmetic is WIDTH+1 wide so the top bit is carry-out (add) or borrow (sub).
    always_comb begin
        w_ext     = '0;
        w_res     = '0;
        w_c       = r_status[1];
        w_v       = r_status[0];
        w_defined = 1'b1;
        case (exe_cmd)
            CMD_MOV: w_res = val2;
            CMD_MVN: w_res = ~val2;
            CMD_ADD, CMD_ADC: begin
                w_ext = {1'b0, val_rn} + {1'b0, val2}
                      + {{WIDTH{1'b0}}, (exe_cmd == CMD_ADC) & w_c_in};
                w_res = w_ext[WIDTH-1:0];
                w_c   = w_ext[WIDTH];
                w_v   = (val_rn[WIDTH-1] == val2[WIDTH-1]) &&
                        (w_res[WIDTH-1] != val_rn[WIDTH-1]);
            end
            CMD_SUB, CMD_SBC: begin
                w_ext = {1'b0, val_rn} - {1'b0, val2}
                      - {{WIDTH{1'b0}}, (exe_cmd == CMD_SBC) & ~w_c_in};
                w_res = w_ext[WIDTH-1:0];
                w_c   = ~w_ext[WIDTH];
                w_v   = (val_rn[WIDTH-1] != val2[WIDTH-1]) &&
                        (w_res[WIDTH-1] != val_rn[WIDTH-1]);
            end
            CMD_AND: w_res = val_rn & val2;
            CMD_ORR: w_res = val_rn | val2;
            CMD_EOR: w_res = val_rn ^ val2;
            default: w_defined = 1'b0;
        endcase
    end

    assign w_flags     = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
    assign w_status_we = valid_in & s_in & w_defined;

    assign w_imm_sext   = {{(WIDTH-24){imm24[23]}}, imm24};
    assign branch_taken = valid_in & b_in & ~flush;
    assign branch_addr  = pc_in + (w_imm_sext << 2);

    // Priority: reset, then flush (bubble, beats freeze), then freeze (hold), then load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_res  <= '0;
            r_st_val   <= '0;
            r_dest     <= '0;
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
            r_mem_w_en <= 1'b0;
            r_valid    <= 1'b0;
            r_status   <= '0;
        end else if (flush) begin
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
            r_mem_w_en <= 1'b0;
            r_valid    <= 1'b0;
        end else if (!freeze) begin
            r_alu_res  <= w_res;
            r_st_val   <= val_rm;
            r_dest     <= dest_in;
            r_wb_en    <= valid_in & wb_en_in;
            r_mem_r_en <= valid_in & mem_r_en_in;
            r_mem_w_en <= valid_in & mem_w_en_in;
            r_valid    <= valid_in;
            if (w_status_we) begin
                r_status <= w_flags;
            end
        end
    end

    assign alu_res  = r_alu_res;
    assign st_val   = r_st_val;
    assign dest     = r_dest;
    assign wb_en    = r_wb_en;
    assign mem_r_en = r_mem_r_en;
    assign mem_w_en = r_mem_w_en;
    assign valid    = r_valid;
    assign status   = r_status;

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage ARM pipeline: it receives the decoded `exe_cmd` plus memory and write-back controls from the ID/EX register and performs the ALU operation. It owns the NZCV status register and drives the branch target. It registers the result and controls into the EX/MEM register, with freeze and flush support for the hazard and branch logic.

## Interface
Parameters:
- `WIDTH`, 32, datapath width.
- `DEST_W`, 4, register-index width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `freeze` in 1: hold all state (stall).
- `flush` in 1: squash the incoming instruction.
- `valid_in` in 1: instruction present in EX.
- `exe_cmd` in 4: ALU command.
- `s_in` in 1: update status.
- `b_in` in 1: branch.
- `mem_r_en_in`, `mem_w_en_in`, `wb_en_in` in 1 each: controls.
- `val_rn` in WIDTH: first operand.
- `val2` in WIDTH: shifted second operand.
- `val_rm` in WIDTH: store data.
- `dest_in` in DEST_W: destination register.
- `pc_in` in WIDTH: PC+4 of this instruction.
- `imm24` in 24: branch offset.
- `alu_res` out WIDTH: registered result.
- `st_val` out WIDTH: registered store data.
- `dest` out DEST_W: registered destination.
- `wb_en`, `mem_r_en`, `mem_w_en`, `valid` out 1 each: registered controls.
- `status` out 4: NZCV, bit3 = N.
- `branch_taken` out 1: combinational.
- `branch_addr` out WIDTH: combinational.

## Operation
`exe_cmd` encoding (C = current status C):
- MOV 0001: val2.
- MVN 1001: ~val2.
- ADD 0010: rn+val2. LDR and STR also use 0010 (address calculation).
- ADC 0011: rn+val2+C.
- SUB 0100: rn−val2. CMP also uses 0100.
- SBC 0101: rn−val2−!C.
- AND 0110: rn&val2. TST also uses 0110.
- ORR 0111: rn|val2.
- EOR 1000: rn^val2.
- Any other code: result 0, status update suppressed.

Flags and width rules:
- Arithmetic is computed WIDTH+1 bits wide.
- N = res[WIDTH−1]; Z = (res == 0).
- Add family: C = carry-out; V = signed overflow, i.e. operands have the same sign and the result sign differs.
- Sub family: C = NOT borrow (rn ≥ val2+!C unsigned); V = operands have different signs and the result sign differs from rn.
- Logic, MOV and MVN: C and V are unchanged.

Status update:
- `status` updates at the edge only when `valid_in & s_in & !flush & !freeze & !rst` and the code is defined.
- ADC and SBC use the pre-edge C.
- Back-to-back S instructions see each other's flags with no bubble.

Branch:
- `branch_taken = valid_in & b_in & !flush`.
- `branch_addr = pc_in + (sign_extend(imm24) << 2)`, with wrap-around modulo 2^WIDTH.

EX/MEM register priority, at each edge:
1. `rst`: all outputs, including status, go to 0.
2. `flush`: `valid`, `wb_en`, `mem_r_en` and `mem_w_en` go to 0; data registers may take any value.
3. `freeze`: all registers and status hold.
4. Otherwise all registers load. If `valid_in` = 0, the controls load as 0.

Additional rules:
- `flush` together with `freeze`: flush wins.
- `branch_taken` is not itself gated by `freeze`. The hazard unit never asserts freeze with a branch in EX.

## Timing
- Result latency is one cycle: operands applied before edge k appear on `alu_res` after edge k.
- `status` reflects an S instruction one cycle after its EX cycle.
- `branch_taken` and `branch_addr` are valid in the same cycle as the inputs.
- Reset asserted mid-stream clears everything on the next edge. The first post-reset instruction uses C = 0.
- Freeze held for N cycles keeps outputs stable for N cycles. The instruction completes on the first non-frozen edge.

## Test plan
- Reset and basic ops:
  - Reset → all outputs 0.
  - MOV val2=0x5, wb_en_in=1, dest_in=3 → next cycle alu_res=5, wb_en=1, dest=3, status=0000.
- Add overflow and carry chain:
  - ADD S=1, rn=0x7FFFFFFF, val2=1 → alu_res=0x80000000, status=1001.
  - Then ADC S=1, rn=0xFFFFFFFF, val2=0, entered with C=1 from a prior ADDS of 0xFFFFFFFF+1 → alu_res=0, status=0110.
- Compare and subtract with carry:
  - CMP S=1, rn=val2=7 → Z=1, C=1, wb_en=0 (as driven by decode).
  - SBC S=0, rn=5, val2=3, C=0 → alu_res=1, status unchanged.
- Logic keeps C and V:
  - With status=0011, EOR S=1, rn=val2=0xA5 → alu_res=0, status=0111 (C and V kept).
- Freeze and flush:
  - ADD S=1 with freeze=1 for 3 cycles → outputs and status unchanged for 3 cycles, updated on the 4th edge.
  - flush=1 with STR → mem_w_en=0, valid=0, status unchanged.
  - flush and freeze together → bubble.
- Branch:
  - b_in=1, pc_in=0x100, imm24=0xFFFFFE → branch_taken=1, branch_addr=0xF8.
  - Same with flush=1 → branch_taken=0.
